// File: rtl/timegen_snapshot_fifo_pkg.sv
// Shared widths, entry layout and helpers for the time-generator snapshot FIFO.
package timegen_snapshot_fifo_pkg;

  localparam int SNAP_DEPTH_LOG2  = 3;
  localparam int SNAP_OVF_WIDTH   = 16;
  localparam int SNAP_ENTRY_WIDTH = 96;

  // One captured snapshot; intr_cnt occupies the top word.
  typedef struct packed {
    logic [31:0] intr_cnt;
    logic [31:0] time_1;
    logic [31:0] time_0;
  } snap_entry_t;

  // Level counter update selected by the accepted write/pop pair.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'b00,
    LVL_DEC  = 2'b01,
    LVL_INC  = 2'b10,
    LVL_SWAP = 2'b11
  } level_op_e;

  function automatic snap_entry_t pack_entry(input logic [31:0] intr_cnt,
                                             input logic [31:0] time_1,
                                             input logic [31:0] time_0);
    snap_entry_t e;
    e.intr_cnt = intr_cnt;
    e.time_1   = time_1;
    e.time_0   = time_0;
    return e;
  endfunction

endpackage

// File: rtl/timegen_snapshot_fifo_if.sv
// Capture/drain bus between the time generator + CPU side and the snapshot FIFO.
interface timegen_snapshot_fifo_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int OVF_WIDTH  = 16
);

  logic                  snap_enable;
  logic                  fix_pulse;
  logic [31:0]           time_0;
  logic [31:0]           time_1;
  logic [31:0]           intr_cnt;
  logic                  rd_pop;
  logic                  ovf_clear;

  logic [31:0]           rd_time_0;
  logic [31:0]           rd_time_1;
  logic [31:0]           rd_intr_cnt;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  ovf_flag;
  logic [OVF_WIDTH-1:0]  ovf_cnt;
  logic                  intr_release;

  // Producer / CPU side.
  modport master (
    output snap_enable, fix_pulse, time_0, time_1, intr_cnt, rd_pop, ovf_clear,
    input  rd_time_0, rd_time_1, rd_intr_cnt, fifo_level, fifo_empty, fifo_full,
           ovf_flag, ovf_cnt, intr_release
  );

  // FIFO side.
  modport slave (
    input  snap_enable, fix_pulse, time_0, time_1, intr_cnt, rd_pop, ovf_clear,
    output rd_time_0, rd_time_1, rd_intr_cnt, fifo_level, fifo_empty, fifo_full,
           ovf_flag, ovf_cnt, intr_release
  );

endinterface

// File: rtl/timegen_snapshot_fifo_mem.sv
// Snapshot storage: one synchronous write port, one asynchronous read port,
// no reset so it maps onto distributed RAM.
module timegen_snapshot_fifo_mem
  import timegen_snapshot_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = SNAP_DEPTH_LOG2
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [DEPTH_LOG2-1:0]       i_waddr,
  input  logic [SNAP_ENTRY_WIDTH-1:0] i_wdata,
  input  logic [DEPTH_LOG2-1:0]       i_raddr,
  output logic [SNAP_ENTRY_WIDTH-1:0] o_rdata
);

  localparam int LP_DEPTH = 1 << DEPTH_LOG2;

  logic [SNAP_ENTRY_WIDTH-1:0] r_mem [LP_DEPTH];

  // Write port: store the entry at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/timegen_snapshot_fifo.sv
// Show-ahead snapshot FIFO behind the time generator. Captures
// {intr_cnt, time_1, time_0} on fix_pulse, lets the CPU drain it with rd_pop,
// counts dropped captures, and pulses intr_release when the CPU empties it.
module timegen_snapshot_fifo
  import timegen_snapshot_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = SNAP_DEPTH_LOG2,
  parameter int OVF_WIDTH  = SNAP_OVF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  timegen_snapshot_fifo_if.slave bus
);

  localparam logic [DEPTH_LOG2:0] LP_FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf_flag;
  logic [OVF_WIDTH-1:0]  r_ovf_cnt;
  logic                  r_intr_release;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_wr_en;
  level_op_e             w_level_op;
  snap_entry_t           w_wr_entry;
  snap_entry_t           w_rd_entry;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LP_FULL_LEVEL);

  // A pop on an empty queue is ignored, so empty+push+pop reduces to a push.
  assign w_push  = bus.snap_enable & bus.fix_pulse;
  assign w_pop   = bus.snap_enable & bus.rd_pop & ~w_empty;
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_wr_en = w_push & ~w_drop;

  assign w_level_op = level_op_e'({w_wr_en, w_pop});
  assign w_wr_entry = pack_entry(bus.intr_cnt, bus.time_1, bus.time_0);

  timegen_snapshot_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // Pointers and level; dropping snap_enable flushes on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (!bus.snap_enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case (w_level_op)
        LVL_INC: r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
        LVL_DEC: r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Overflow bookkeeping; a clear beats a simultaneous drop, and a flush keeps it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (bus.ovf_clear) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (w_drop) begin
      r_ovf_flag <= 1'b1;
      if (r_ovf_cnt != '1) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_WIDTH'(1);
      end
    end
  end

  // One-cycle release pulse when the CPU pops the last entry and nothing refills it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_intr_release <= 1'b0;
    end else begin
      r_intr_release <= w_pop & ~w_push & (r_level == (DEPTH_LOG2 + 1)'(1));
    end
  end

  assign bus.rd_time_0    = w_empty ? '0 : w_rd_entry.time_0;
  assign bus.rd_time_1    = w_empty ? '0 : w_rd_entry.time_1;
  assign bus.rd_intr_cnt  = w_empty ? '0 : w_rd_entry.intr_cnt;
  assign bus.fifo_level   = r_level;
  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.ovf_flag     = r_ovf_flag;
  assign bus.ovf_cnt      = r_ovf_cnt;
  assign bus.intr_release = r_intr_release;

endmodule
